// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_pkg
// Purpose  : Shared pipeline types and widths for the register-file write
//            port arbiter, its result FIFO and the writeback stage.
// Contents : REG_W/DATA_W widths, wb_req_t writeback request, grant_e
//            arbitration outcome, rd_match lookup helper.
// Revision : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    // Writeback request as produced by the WB stage.
    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Owner of the register-file write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_FIFO = 2'd2
    } grant_e;

    // Register 0 is hardwired, so a zero query never creates a hazard.
    function automatic logic rd_match(input logic [REG_W-1:0] q,
                                      input logic [REG_W-1:0] rd);
        return (q != '0) && (q == rd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_if
// Purpose  : Bundles the writeback, multi-cycle, register-file and decode
//            lookup signals of the write-port arbiter.
// Modports : master - environment side (drives requests/queries)
//            slave  - arbiter side (drives grants, rf write, mc_ready, q_hit)
// Revision : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic              pipe_we;
    logic [REG_W-1:0]  pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              mc_valid;
    logic [REG_W-1:0]  mc_rd;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;
    logic              pipe_stall;
    logic              rf_we;
    logic [REG_W-1:0]  rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [REG_W-1:0]  q_rs;
    logic [REG_W-1:0]  q_rt;
    logic              q_hit;

    modport master (
        output pipe_we, pipe_rd, pipe_data,
        output mc_valid, mc_rd, mc_data,
        output q_rs, q_rt,
        input  mc_ready, pipe_stall,
        input  rf_we, rf_wa, rf_wd,
        input  q_hit
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_data,
        input  mc_valid, mc_rd, mc_data,
        input  q_rs, q_rt,
        output mc_ready, pipe_stall,
        output rf_we, rf_wa, rf_wd,
        output q_hit
    );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_fifo
// Purpose  : Small in-order queue of multi-cycle results awaiting the
//            register-file write port. Each entry carries a valid bit that a
//            younger pipeline write to the same rd can clear (WAW squash).
// Ports    : clk, rst_n          - clock, async active-low reset
//            i_push_*            - enqueue (caller guarantees !o_full)
//            i_pop_en            - drop head (caller guarantees !o_empty)
//            i_squash_en/_rd     - clear valid of every entry with this rd
//            i_q_rs/i_q_rt       - lookup addresses, o_q_hit result
//            o_full/o_empty      - occupancy (squashed slots still occupy)
//            o_head_*            - head entry fields
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_push_en,
    input  wire logic [REG_W-1:0]  i_push_rd,
    input  wire logic [DATA_W-1:0] i_push_data,
    input  wire logic              i_pop_en,
    input  wire logic              i_squash_en,
    input  wire logic [REG_W-1:0]  i_squash_rd,
    input  wire logic [REG_W-1:0]  i_q_rs,
    input  wire logic [REG_W-1:0]  i_q_rt,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_head_valid,
    output logic [REG_W-1:0]       o_head_rd,
    output logic [DATA_W-1:0]      o_head_data,
    output logic                   o_q_hit
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    logic [REG_W-1:0]  r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DEPTH-1:0]  w_hit_vec;
    logic              w_push_live;

    assign o_full       = (r_count == C_FULL_CNT);
    assign o_empty      = (r_count == '0);
    assign o_head_valid = r_valid[r_rd_ptr];
    assign o_head_rd    = r_rd[r_rd_ptr];
    assign o_head_data  = r_data[r_rd_ptr];

    // A pipeline write to the same rd on the enqueue edge is younger in
    // program order, so the arriving result is born already squashed.
    assign w_push_live = !(i_squash_en && (i_squash_rd == i_push_rd));

    // Payload storage needs no reset: the valid bits and count gate all use.
    always_ff @(posedge clk) begin
        if (i_push_en) begin
            r_rd[r_wr_ptr]   <= i_push_rd;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Later assignments win: squash, then pop, then the new entry.
            for (int i = 0; i < DEPTH; i++) begin
                if (i_squash_en && (r_rd[i] == i_squash_rd)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            // Clearing on pop keeps "valid" meaning "valid and occupied",
            // which lets the lookup ignore the pointers entirely.
            if (i_pop_en) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + C_PTR_ONE;
            end
            if (i_push_en) begin
                r_valid[r_wr_ptr] <= w_push_live;
                r_wr_ptr          <= r_wr_ptr + C_PTR_ONE;
            end
            unique case ({i_push_en, i_pop_en})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lookup
        assign w_hit_vec[gi] = r_valid[gi] &&
                               (rd_match(i_q_rs, r_rd[gi]) || rd_match(i_q_rt, r_rd[gi]));
    end

    assign o_q_hit = |w_hit_vec;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the single register-file write port between the
//            writeback stage (priority) and queued multi-cycle results.
//            After STARVE_MAX consecutive pipeline wins over a live FIFO
//            head, one FIFO drain is forced and the pipeline is stalled.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            bus   - wb_port_arbiter_if.slave:
//                    pipe_we/rd/data  writeback request, pipe_stall back
//                    mc_valid/rd/data multi-cycle result, mc_ready back
//                    rf_we/wa/wd      register-file write port
//                    q_rs/q_rt        decode query, q_hit pending match
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    wb_port_arbiter_if.slave    bus
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] C_STARVE_ONE = STARVE_W'(1);

    wb_req_t             w_pipe;
    logic                w_preq;
    logic                w_head_ok;
    logic                w_force;
    grant_e              w_grant;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_head_valid;
    logic [REG_W-1:0]    w_head_rd;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_fifo_hit;
    logic                w_push_en;
    logic                w_pop_en;

    logic                w_rf_we;
    logic [REG_W-1:0]    w_rf_wa;
    logic [DATA_W-1:0]   w_rf_wd;

    logic [STARVE_W-1:0] r_starve_cnt;

    assign w_pipe = '{we: bus.pipe_we, rd: bus.pipe_rd, data: bus.pipe_data};

    // A write to r0 is absorbed here and never competes for the port.
    assign w_preq    = w_pipe.we && (w_pipe.rd != '0);
    assign w_head_ok = !w_fifo_empty && w_head_valid;
    assign w_force   = w_head_ok && (r_starve_cnt == C_STARVE_MAX);

    always_comb begin
        w_grant = GNT_NONE;
        if (w_force) begin
            w_grant = GNT_FIFO;
        end else if (w_preq) begin
            w_grant = GNT_PIPE;
        end else if (w_head_ok) begin
            w_grant = GNT_FIFO;
        end
    end

    // Results to r0 carry no architectural effect and are dropped at entry.
    assign w_push_en = bus.mc_valid && !w_fifo_full && (bus.mc_rd != '0);

    // A squashed head leaves without a port cycle, so drains stay dense.
    assign w_pop_en  = (w_grant == GNT_FIFO) || (!w_fifo_empty && !w_head_valid);

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_en    (w_push_en),
        .i_push_rd    (bus.mc_rd),
        .i_push_data  (bus.mc_data),
        .i_pop_en     (w_pop_en),
        .i_squash_en  (w_grant == GNT_PIPE),
        .i_squash_rd  (w_pipe.rd),
        .i_q_rs       (bus.q_rs),
        .i_q_rt       (bus.q_rt),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_head_valid (w_head_valid),
        .o_head_rd    (w_head_rd),
        .o_head_data  (w_head_data),
        .o_q_hit      (w_fifo_hit)
    );

    // Outputs are gated by rst_n so they drop the instant reset asserts,
    // even while the writeback stage is still presenting a request.
    always_comb begin
        w_rf_we = 1'b0;
        w_rf_wa = '0;
        w_rf_wd = '0;
        if (rst_n) begin
            unique case (w_grant)
                GNT_PIPE: begin
                    w_rf_we = 1'b1;
                    w_rf_wa = w_pipe.rd;
                    w_rf_wd = w_pipe.data;
                end
                GNT_FIFO: begin
                    w_rf_we = 1'b1;
                    w_rf_wa = w_head_rd;
                    w_rf_wd = w_head_data;
                end
                default: begin
                    w_rf_we = 1'b0;
                end
            endcase
        end
    end

    assign bus.rf_we      = w_rf_we;
    assign bus.rf_wa      = w_rf_wa;
    assign bus.rf_wd      = w_rf_wd;
    assign bus.pipe_stall = rst_n && w_force && w_preq;
    assign bus.mc_ready   = rst_n && !w_fifo_full;
    assign bus.q_hit      = rst_n && w_fifo_hit;

    // Counts pipeline wins that bypassed a live head; a squashed head
    // neither advances nor clears it, since it pops without the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if ((w_grant == GNT_FIFO) || w_fifo_empty) begin
            r_starve_cnt <= '0;
        end else if ((w_grant == GNT_PIPE) && w_head_ok &&
                     (r_starve_cnt != C_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + C_STARVE_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter. A queue-based model
//            predicts each cycle's outputs into a scoreboard; a monitor on
//            the falling edge pops and compares against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } m_entry_t;

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          stall;
        bit          ready;
        bit          hit;
    } exp_t;

    m_entry_t mq[$];
    exp_t     sb[$];
    int       starve   = 0;
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp_v);
        end
    endtask

    // One cycle: drive inputs, predict outputs from the queue model, advance.
    task automatic drive(input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] qrs, input logic [4:0] qrt,
                         output bit stalled);
        exp_t     e;
        m_entry_t n;
        bit       preq, head_ok, frc, ready, pipe_gnt, fifo_gnt, was_empty;
        bus.pipe_we = pwe;  bus.pipe_rd = prd;  bus.pipe_data = pd;
        bus.mc_valid = mv;  bus.mc_rd = mrd;    bus.mc_data = md;
        bus.q_rs = qrs;     bus.q_rt = qrt;

        preq      = pwe && (prd != 0);
        was_empty = (mq.size() == 0);
        head_ok   = !was_empty && mq[0].live;
        frc       = head_ok && (starve == STARVE_MAX);
        ready     = (mq.size() < DEPTH);
        fifo_gnt  = frc || (!preq && head_ok);
        pipe_gnt  = preq && !frc;

        e = '{we: 0, wa: 0, wd: 0, stall: 0, ready: ready, hit: 0};
        foreach (mq[i])
            if (mq[i].live && ((qrs != 0 && mq[i].rd == qrs) || (qrt != 0 && mq[i].rd == qrt)))
                e.hit = 1;
        if (fifo_gnt) begin
            e.we = 1; e.wa = mq[0].rd; e.wd = mq[0].data; e.stall = preq;
        end else if (pipe_gnt) begin
            e.we = 1; e.wa = prd; e.wd = pd;
        end
        sb.push_back(e);
        stalled = e.stall;

        if (fifo_gnt) starve = 0;
        else if (pipe_gnt && head_ok) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
        else if (was_empty) starve = 0;

        if (!was_empty && (fifo_gnt || !mq[0].live)) void'(mq.pop_front());
        if (pipe_gnt) foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 0;
        if (mv && ready && mrd != 0) begin
            n.rd = mrd; n.data = md; n.live = !(pipe_gnt && prd == mrd);
            mq.push_back(n);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, s);
    endtask

    // Monitor: one scoreboard entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rf_we",      32'(bus.rf_we),      32'(e.we));
                check("rf_wa",      32'(bus.rf_wa),      32'(e.wa));
                check("rf_wd",      bus.rf_wd,           e.wd);
                check("pipe_stall", 32'(bus.pipe_stall), 32'(e.stall));
                check("mc_ready",   32'(bus.mc_ready),   32'(e.ready));
                check("q_hit",      32'(bus.q_hit),      32'(e.hit));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_we"},      32'(bus.rf_we),      0);
        check({tag, "_rf_wa"},      32'(bus.rf_wa),      0);
        check({tag, "_rf_wd"},      bus.rf_wd,           0);
        check({tag, "_pipe_stall"}, 32'(bus.pipe_stall), 0);
        check({tag, "_mc_ready"},   32'(bus.mc_ready),   0);
        check({tag, "_q_hit"},      32'(bus.q_hit),      0);
    endtask

    initial begin
        bit          s, acc;
        logic [31:0] pdat;
        logic [4:0]  mrds[3];
        int          mi;
        bit          p_we;
        logic [4:0]  p_rd;
        logic [31:0] p_d;

        // Reset state, with a live pipeline request present.
        bus.pipe_we = 1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'h1234;
        bus.mc_valid = 1; bus.mc_rd = 5'd6; bus.mc_data = 32'h55;
        bus.q_rs = 5'd6; bus.q_rt = 5'd6;
        #2;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;

        // Idle port: single result drains the next cycle.
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, s);
        idle(3);

        // Priority and forced drain.
        pdat = 32'h300;
        drive(1, 5'd3, pdat, 1, 5'd7, 32'h777, 0, 0, s);
        for (int i = 0; i < 8; i++) begin
            if (!s) pdat = pdat + 1;
            drive(1, 5'd3, pdat, 0, 0, 0, 5'd7, 0, s);
        end
        idle(2);

        // Full FIFO with continuous pipeline traffic; results held until taken.
        mrds[0] = 5'd1; mrds[1] = 5'd2; mrds[2] = 5'd4;
        mi = 0;
        for (int i = 0; i < 24; i++) begin
            if (!s) pdat = pdat + 1;
            acc = (mi < 3) && (mq.size() < DEPTH);
            drive(1, 5'd3, pdat, mi < 3, (mi < 3) ? mrds[mi] : 5'd0, 32'hA0 + mi, 5'd4, 0, s);
            if (acc) mi++;
        end
        idle(4);

        // WAW squash.
        drive(1, 5'd3, 32'h1, 1, 5'd9, 32'h11, 0, 0, s);
        drive(1, 5'd9, 32'h22, 0, 0, 0, 5'd9, 0, s);
        idle(3);

        // Lookup and r0 query.
        drive(1, 5'd3, 32'h2, 1, 5'd12, 32'hC0, 5'd12, 0, s);
        drive(1, 5'd3, 32'h3, 0, 0, 0, 5'd12, 0, s);
        drive(1, 5'd3, 32'h4, 0, 0, 0, 0, 0, s);
        drive(0, 0, 0, 0, 0, 0, 0, 5'd12, s);
        drive(0, 0, 0, 0, 0, 0, 5'd12, 5'd12, s);
        idle(2);

        // Asynchronous reset with two queued entries.
        drive(1, 5'd3, 32'h5, 1, 5'd10, 32'hA10, 0, 0, s);
        drive(1, 5'd3, 32'h6, 1, 5'd11, 32'hA11, 0, 0, s);
        bus.pipe_we = 1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h7;
        bus.mc_valid = 1; bus.mc_rd = 5'd13; bus.mc_data = 32'hA13;
        bus.q_rs = 5'd10; bus.q_rt = 5'd11;
        #2 rst_n = 0;
        #1;
        check_all_zero("async_rst");
        sb.push_back('{we: 0, wa: 0, wd: 0, stall: 0, ready: 0, hit: 0});
        mq.delete();
        starve = 0;
        @(posedge clk); #1;
        sb.push_back('{we: 0, wa: 0, wd: 0, stall: 0, ready: 0, hit: 0});
        @(posedge clk); #1;
        rst_n = 1;
        drive(0, 0, 0, 0, 0, 0, 5'd10, 5'd11, s);
        idle(3);

        // Randomized traffic; a stalled pipeline request is retried unchanged.
        s = 0;
        p_we = 0; p_rd = 0; p_d = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!s) begin
                p_we = ($urandom_range(0, 3) != 0);
                p_rd = 5'($urandom_range(0, 7));
                p_d  = $urandom;
            end
            drive(p_we, p_rd, p_d,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), s);
        end
        idle(6);

        @(negedge clk); @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
